// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register scoreboard, stall/flush sequencing and deadlock watchdog for an in-order pipeline
module hazard_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_id_valid,
    input  logic [4:0]  i_rs1_number,
    input  logic [4:0]  i_rs2_number,
    input  logic [4:0]  i_rd_number,
    input  logic [6:0]  i_opcode,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_redirect,
    input  logic        i_mem_busy,
    output logic        o_pipeline_stall,
    output logic        o_load_new_pc,
    output logic        o_issue,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_count,
    output logic        o_deadlock
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [3:0] FLOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        dl_q, dl_d;
    logic        haz, stall_cond, writer, flush;
    logic [31:0] set_v, clr_v;

    // A source is blocked only if pending and not being written back this very cycle
    always_comb begin
        haz = i_id_valid &&
              ((pend_q[i_rs1_number] && !(i_wb_valid && i_wb_rd == i_rs1_number)) ||
               (pend_q[i_rs2_number] && !(i_wb_valid && i_wb_rd == i_rs2_number)));
        stall_cond = i_mem_busy || haz;
        writer = i_opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111};
    end

    // State and flush counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: redirect always (re)enters FLUSH, FLUSH counts down to RUN
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (i_redirect) begin
            state_d = FLUSH;
            fcnt_d  = FLOAD;
        end else if (state_q == FLUSH) begin
            state_d = fcnt_q == 4'd0 ? RUN : FLUSH;
            fcnt_d  = fcnt_q == 4'd0 ? 4'd0 : fcnt_q - 4'd1;
        end else begin
            state_d = stall_cond ? STALL : RUN;
        end
    end

    // Pipeline control outputs; FLUSH suppresses both stall and issue
    always_comb begin
        flush            = state_q == FLUSH;
        o_pipeline_stall = !flush && stall_cond && !i_redirect;
        o_issue          = !flush && i_id_valid && !stall_cond && !i_redirect;
        o_load_new_pc    = i_redirect || flush;
        o_state          = state_q;
        o_stall_count    = cnt_q;
        o_deadlock       = dl_q;
    end

    // Scoreboard and counter next values; a same-cycle set wins over clear
    always_comb begin
        set_v  = (o_issue && writer && i_rd_number != 5'd0) ? 32'd1 << i_rd_number : '0;
        clr_v  = (i_wb_valid && i_wb_rd != 5'd0) ? 32'd1 << i_wb_rd : '0;
        pend_d = (pend_q & ~clr_v) | set_v;
        cnt_d  = (o_pipeline_stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
        tmo_d  = !o_pipeline_stall ? '0 : (tmo_q != '1 ? tmo_q + 16'd1 : tmo_q);
        dl_d   = dl_q || (tmo_d == 16'(STALL_TIMEOUT));
    end

    // Scoreboard, stall statistics and sticky deadlock registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
            dl_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            dl_q   <= dl_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario bench with an expectation queue for hazard_ctrl
module tb_hazard_ctrl;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_id_valid, i_wb_valid, i_redirect, i_mem_busy;
    logic [4:0]  i_rs1_number, i_rs2_number, i_rd_number, i_wb_rd;
    logic [6:0]  i_opcode;
    logic        o_pipeline_stall, o_load_new_pc, o_issue, o_deadlock;
    logic [1:0]  o_state;
    logic [31:0] o_stall_count;

    int n_chk = 0;
    int n_fail = 0;
    logic [5:0] exp_q[$];

    hazard_ctrl #(.FLUSH_CYCLES(2), .STALL_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .i_id_valid(i_id_valid),
        .i_rs1_number(i_rs1_number), .i_rs2_number(i_rs2_number), .i_rd_number(i_rd_number),
        .i_opcode(i_opcode), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
        .i_redirect(i_redirect), .i_mem_busy(i_mem_busy),
        .o_pipeline_stall(o_pipeline_stall), .o_load_new_pc(o_load_new_pc), .o_issue(o_issue),
        .o_state(o_state), .o_stall_count(o_stall_count), .o_deadlock(o_deadlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of ID/WB/EX inputs, queue the expected outputs, then compare before the edge
    task automatic step(input string tag, input logic idv, input logic [4:0] rs1, rs2, rd,
                        input logic [6:0] op, input logic wbv, input logic [4:0] wbrd,
                        input logic rdr, busy, input logic [1:0] e_state,
                        input logic e_stall, e_issue, e_lnpc, e_dl);
        logic [5:0] e;
        @(negedge clk);
        i_id_valid = idv; i_rs1_number = rs1; i_rs2_number = rs2; i_rd_number = rd;
        i_opcode = op; i_wb_valid = wbv; i_wb_rd = wbrd; i_redirect = rdr; i_mem_busy = busy;
        exp_q.push_back({e_state, e_stall, e_issue, e_lnpc, e_dl});
        #4;
        e = exp_q.pop_front();
        check({tag, ".state"}, 32'(o_state), 32'(e[5:4]));
        check({tag, ".stall"}, 32'(o_pipeline_stall), 32'(e[3]));
        check({tag, ".issue"}, 32'(o_issue), 32'(e[2]));
        check({tag, ".lnpc"}, 32'(o_load_new_pc), 32'(e[1]));
        check({tag, ".dl"}, 32'(o_deadlock), 32'(e[0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {i_id_valid, i_wb_valid, i_redirect, i_mem_busy} = '0;
        {i_rs1_number, i_rs2_number, i_rd_number, i_wb_rd} = '0;
        i_opcode = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.state", 32'(o_state), 0);
        check("rst.count", o_stall_count, 0);
        check("rst.dl", 32'(o_deadlock), 0);
        check("rst.stall", 32'(o_pipeline_stall), 0);
        check("rst.lnpc", 32'(o_load_new_pc), 0);
        reset = 1'b1;

        step("dl1", 0, 0, 0, 0, BR, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0);
        step("dl2", 0, 0, 0, 0, BR, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0);
        step("dl3", 0, 0, 0, 0, BR, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0);
        step("dl4", 0, 0, 0, 0, BR, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0);
        step("dl_set", 0, 0, 0, 0, BR, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1);
        check("dl.count", o_stall_count, 4);
        step("dl_sticky", 0, 0, 0, 0, BR, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2.dl", 32'(o_deadlock), 0);
        check("rst2.count", o_stall_count, 0);
        @(negedge clk);
        reset = 1'b1;

        step("raw_set", 1, 0, 0, 5, ADDI, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
        step("raw_st1", 1, 5, 0, 0, BR, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        step("raw_st2", 1, 5, 0, 0, BR, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0);
        step("raw_wt", 1, 5, 0, 0, BR, 1, 5, 0, 0, 2'd1, 0, 1, 0, 0);
        check("raw.count", o_stall_count, 2);

        step("x0_set", 1, 0, 0, 0, ADDI, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
        step("x0_rd", 1, 0, 0, 0, BR, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);

        step("rd_set", 1, 0, 0, 9, ADDI, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
        step("rd_st1", 1, 0, 9, 0, BR, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        step("rd_st2", 1, 0, 9, 0, BR, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0);
        step("rd_redir", 1, 0, 9, 0, BR, 0, 0, 1, 0, 2'd1, 0, 0, 1, 0);
        step("rd_fl1", 1, 0, 9, 0, BR, 0, 0, 0, 0, 2'd2, 0, 0, 1, 0);
        step("rd_fl2", 1, 0, 9, 0, BR, 0, 0, 0, 0, 2'd2, 0, 0, 1, 0);
        step("rd_run", 1, 0, 9, 0, BR, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        step("rd_wt", 1, 0, 9, 0, BR, 1, 9, 0, 0, 2'd1, 0, 1, 0, 0);

        step("sc_both", 1, 0, 0, 7, ADDI, 1, 7, 0, 0, 2'd0, 0, 1, 0, 0);
        step("sc_st", 1, 7, 0, 0, BR, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        step("sc_wt", 1, 7, 0, 0, BR, 1, 7, 0, 0, 2'd1, 0, 1, 0, 0);
        check("sc.count", o_stall_count, 6);

        step("ar_set", 1, 0, 0, 12, ADDI, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
        step("ar_redir", 0, 0, 0, 0, BR, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0);
        step("ar_fl1", 0, 0, 0, 0, BR, 0, 0, 0, 0, 2'd2, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        check("ar.pre", 32'(o_state), 2);
        #1;
        reset = 1'b0;
        #1;
        check("ar.state", 32'(o_state), 0);
        check("ar.count", o_stall_count, 0);
        check("ar.lnpc", 32'(o_load_new_pc), 0);
        @(negedge clk);
        reset = 1'b1;
        step("ar_empty", 1, 12, 0, 0, BR, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles the FLUSH state holds the squash (legal range 1..15).
REQ-002 Parameter STALL_TIMEOUT, default 1024: consecutive stall cycles that set o_deadlock (legal range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_id_valid  input  1  ID stage holds a decoded instruction.
REQ-006 i_rs1_number, i_rs2_number, i_rd_number  input  5 each  decoded register numbers; unused fields arrive as 0.
REQ-007 i_opcode  input  7  decoded opcode.
REQ-008 i_wb_valid  input  1; i_wb_rd  input  5  writeback of register i_wb_rd this cycle.
REQ-009 i_redirect  input  1  EX resolved a taken branch, JAL or JALR this cycle.
REQ-010 i_mem_busy  input  1  memory stage cannot accept.
REQ-011 o_pipeline_stall  output  1  freeze IF/ID.
REQ-012 o_load_new_pc  output  1  squash IF/ID contents.
REQ-013 o_issue  output  1  ID instruction is accepted into EX this cycle.
REQ-014 o_state  output  2  RUN=0, STALL=1, FLUSH=2.
REQ-015 o_stall_count  output  32  saturating count of stall cycles.
REQ-016 o_deadlock  output  1  sticky timeout flag.

Function
REQ-017 Scoreboard: 31 pending bits for x1..x31; x0 is never pending.
REQ-018 A register is a hazard when it is pending and not being cleared this cycle by i_wb_valid with i_wb_rd equal to it (write-through view).
REQ-019 hazard = i_id_valid AND (i_rs1_number is a hazard OR i_rs2_number is a hazard).
REQ-020 stall_cond = i_mem_busy OR hazard.
REQ-021 Combinational outputs in RUN/STALL: o_pipeline_stall = stall_cond AND NOT i_redirect; o_issue = i_id_valid AND NOT stall_cond AND NOT i_redirect.
REQ-022 In FLUSH: o_pipeline_stall=0, o_issue=0.
REQ-023 o_load_new_pc = i_redirect OR (state == FLUSH).
REQ-024 Writer opcodes: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
REQ-025 Set: on o_issue with a writer opcode and i_rd_number != 0, set pending[i_rd_number] at the next edge.
REQ-026 Clear: on i_wb_valid with i_wb_rd != 0, clear pending[i_wb_rd]; when set and clear hit the same register in one cycle, the bit ends set.
REQ-027 i_redirect leaves the scoreboard unchanged; older instructions still write back.
REQ-028 Transitions from RUN: i_redirect -> FLUSH; else stall_cond -> STALL; else stay in RUN.
REQ-029 Transitions from STALL: i_redirect -> FLUSH; else NOT stall_cond -> RUN; else stay in STALL.
REQ-030 Transitions from FLUSH: i_redirect reloads the flush counter and stays in FLUSH; else counter == 0 -> RUN; else decrement the counter.
REQ-031 Flush counter: entering or reloading FLUSH loads FLUSH_CYCLES-1, so FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-032 o_stall_count: +1 on each cycle with o_pipeline_stall=1; holds at 0xFFFFFFFF.
REQ-033 Timeout counter (16 bits): +1 on each cycle with o_pipeline_stall=1; cleared on any cycle with o_pipeline_stall=0.
REQ-034 When the timeout counter reaches STALL_TIMEOUT, set o_deadlock; o_deadlock stays set until reset.

Reset
REQ-035 While reset=0, immediately: state=RUN, all pending bits=0, flush counter=0, o_stall_count=0, timeout counter=0, o_deadlock=0.
REQ-036 Reset asserted mid-STALL or mid-FLUSH abandons the operation; the first cycle after release is RUN with an empty scoreboard.

Verification
REQ-037 RAW stall: issue addi x5 (rd=5); next cycle ID reads rs1=5 -> o_pipeline_stall=1 and o_state=STALL until a cycle with i_wb_valid, i_wb_rd=5, in which o_issue=1 (write-through).
REQ-038 x0: issue with rd=0, then read rs1=0 -> no stall; pending stays all-zero.
REQ-039 Redirect during STALL: i_redirect=1 -> o_load_new_pc=1 and o_pipeline_stall=0 that cycle; FLUSH for 2 cycles with o_issue=0; RUN on the 3rd cycle; scoreboard unchanged.
REQ-040 Same-register set and clear: issue rd=7 while i_wb_rd=7 -> pending[7]=1 afterwards; a following reader of x7 stalls.
REQ-041 Timeout: i_mem_busy held high with STALL_TIMEOUT=4 -> o_deadlock=1 after 4 stall cycles, o_stall_count=4 at that point; o_deadlock stays 1 after busy drops.
REQ-042 Async reset mid-FLUSH: reset=0 between edges -> outputs reset immediately (o_state=0, o_stall_count=0).
